multicycle_ctrl: RTL

Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback around the instruction decoder and shared datapath. It consumes the decoded opcode/func3/func7 fields of the latched instruction register and drives datapath enables, mux selects and ALU op. It handshakes with instruction and data memory, traps on illegal opcodes or memory timeout, and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multi-cycle RV32I core. Walks each instruction through
// FETCH -> DECODE -> EXECUTE -> (MEM) -> WB. It reads the decoded fields of the
// latched instruction register and drives the datapath enables, mux selects
// and ALU op. It handshakes with instruction and data memory, traps on illegal
// encodings or a memory that never answers, and counts retired instructions.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   opcode/func3/func7   decoded fields of the instruction register
//   br_taken             branch comparator result, sampled in EXECUTE
//   imem_req/imem_ready  instruction fetch handshake
//   dmem_req/dmem_we     data access request, 1 = store
//   dmem_ready           data access complete this cycle
//   ir_we                load instruction register
//   pc_we, pc_sel        PC update strobe (retire), 0 = PC+4, 1 = ALU-out
//   reg_we, wb_sel       register write enable and writeback source
//   alu_src_a/b, imm_sel ALU operand selects and immediate format
//   alu_op               {bit30 qualifier, func3}
//   state                current state encoding
//   fault                sticky trap indicator
//   instret              retired-instruction counter
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic [2:0]  func3,
   input  logic [6:0]  func7,
   input  logic        br_taken,
   output logic        imem_req,
   input  logic        imem_ready,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ready,
   output logic        ir_we,
   output logic        pc_we,
   output logic        pc_sel,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic        alu_src_a,
   output logic        alu_src_b,
   output logic [2:0]  imm_sel,
   output logic [3:0]  alu_op,
   output logic [2:0]  state,
   output logic        fault,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_TRAP    = 3'd5
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [16:0] TMO_LIMIT = 17'(MEM_TIMEOUT);

   state_t      state_q, state_d;
   logic [15:0] tmo_q, tmo_d;
   logic        br_q, br_d;
   logic [31:0] instret_q, instret_d;

   // ---------------- instruction class decode ----------------
   logic is_r, is_ialu, is_load, is_store, is_branch;
   logic is_jal, is_jalr, is_lui, is_auipc;
   logic is_shift, f7_ok, legal, tmo_hit;

   assign is_r      = (opcode == OP_R);
   assign is_ialu   = (opcode == OP_IALU);
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_jal    = (opcode == OP_JAL);
   assign is_jalr   = (opcode == OP_JALR);
   assign is_lui    = (opcode == OP_LUI);
   assign is_auipc  = (opcode == OP_AUIPC);

   assign is_shift = is_ialu && ((func3 == 3'b001) || (func3 == 3'b101));

   // func7 may be zero, or carry only bit 30 for ADD/SUB and SRL/SRA.
   // For I-shifts this leaves SRAI as the only user of bit 30.
   assign f7_ok = (func7 == 7'b000_0000) ||
                  ((func7 == 7'b010_0000) && ((func3 == 3'b000) || (func3 == 3'b101)));

   // Non-shift I-ALU instructions carry immediate bits in func7, so no check.
   assign legal = (is_r && f7_ok) || (is_ialu && (!is_shift || f7_ok)) ||
                  is_load || is_store || is_branch || is_jal || is_jalr ||
                  is_lui || is_auipc;

   // The cycle being evaluated is wait cycle tmo_q+1; a ready in this same
   // cycle takes priority over the trap.
   assign tmo_hit = ({1'b0, tmo_q} + 17'd1) >= TMO_LIMIT;

   // ---------------- next state ----------------
   always_comb begin
      state_d   = state_q;
      tmo_d     = tmo_q;
      br_d      = br_q;
      instret_d = instret_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ready)   state_d = S_DECODE;
            else if (tmo_hit) state_d = S_TRAP;
            else              tmo_d   = tmo_q + 16'd1;
         end
         S_DECODE: begin
            state_d = legal ? S_EXECUTE : S_TRAP;
         end
         S_EXECUTE: begin
            br_d = br_taken;
            if (is_load || is_store) begin
               state_d = S_MEM;
               tmo_d   = '0;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (dmem_ready) begin
               if (is_store) begin
                  state_d = S_FETCH;
                  tmo_d   = '0;
               end else begin
                  state_d = S_WB;
               end
            end else if (tmo_hit) begin
               state_d = S_TRAP;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            tmo_d   = '0;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
      if (pc_we) instret_d = instret_q + 32'd1;
   end

   // ---------------- control outputs ----------------
   // Decoded from state and IR fields; the ready inputs only qualify the
   // completion strobes. Everything is forced low while rst is high so a
   // mid-transaction reset drops requests immediately.
   always_comb begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 1'b0;
      reg_we    = 1'b0;
      wb_sel    = 2'b00;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      imm_sel   = IMM_I;
      alu_op    = 4'b0000;
      fault     = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_we    = imem_ready;
            end
            S_EXECUTE: begin
               if (is_r || is_shift) alu_op = {func7[5], func3};
               else if (is_ialu)     alu_op = {1'b0, func3};
               alu_src_a = is_branch || is_jal || is_auipc;
               alu_src_b = !is_r && !is_lui;
               if (is_store)                imm_sel = IMM_S;
               else if (is_branch)          imm_sel = IMM_B;
               else if (is_lui || is_auipc) imm_sel = IMM_U;
               else if (is_jal)             imm_sel = IMM_J;
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = is_store;
               pc_we    = is_store && dmem_ready;
            end
            S_WB: begin
               pc_we  = 1'b1;
               reg_we = !is_branch;
               pc_sel = is_jal || is_jalr || (is_branch && br_q);
               if (is_load)                wb_sel = 2'b01;
               else if (is_jal || is_jalr) wb_sel = 2'b10;
               else if (is_lui)            wb_sel = 2'b11;
            end
            S_TRAP:  fault = 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         tmo_q     <= '0;
         br_q      <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         br_q      <= br_d;
         instret_q <= instret_d;
      end
   end

   assign state   = state_q;
   assign instret = instret_q;

endmodule
